// File: rtl/iob_plic_claim_ctrl_if.sv
// Bundle of the controller's two channels:
//  - IOb master port toward the PLIC slave (claim read / complete write)
//  - interrupt hand-off channel toward the handler (valid/ready + done)
// Signal names keep the original port names so existing netlists map 1:1.
// master modport: the claim/complete controller.
// slave modport : the PLIC + handler side.
//  iob_avalid_o / iob_addr_o / iob_wdata_o / iob_wstrb_o : IOb request (wstrb 0 = read)
//  iob_ready_i / iob_rvalid_i / iob_rdata_i               : IOb accept / read response
//  irq_valid_o / irq_tgt_o / irq_id_o / irq_ready_i       : claimed interrupt offer
//  done_i                                                 : handler finished pulse
interface iob_plic_claim_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned TGT_W  = 1
);
  logic                  iob_avalid_o;
  logic [ADDR_W-1:0]     iob_addr_o;
  logic [DATA_W-1:0]     iob_wdata_o;
  logic [DATA_W/8-1:0]   iob_wstrb_o;
  logic                  iob_ready_i;
  logic                  iob_rvalid_i;
  logic [DATA_W-1:0]     iob_rdata_i;
  logic                  irq_valid_o;
  logic                  irq_ready_i;
  logic [TGT_W-1:0]      irq_tgt_o;
  logic [ID_W-1:0]       irq_id_o;
  logic                  done_i;

  modport master (
    output iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    input  iob_ready_i, iob_rvalid_i, iob_rdata_i,
    output irq_valid_o, irq_tgt_o, irq_id_o,
    input  irq_ready_i, done_i
  );

  modport slave (
    input  iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    output iob_ready_i, iob_rvalid_i, iob_rdata_i,
    input  irq_valid_o, irq_tgt_o, irq_id_o,
    output irq_ready_i, done_i
  );
endinterface

// File: rtl/iob_plic_claim_ctrl.sv
// Hardware claim/complete sequencer for iob_plic.
// Picks one pending PLIC target round-robin, reads its claim register over
// IOb, offers the claimed ID to a handler, waits for done, then writes the ID
// back to the complete register. One interrupt in flight at a time.
// Ports:
//  clk_i      : clock, rising edge
//  rst_n_i    : synchronous active-low reset
//  meip_i     : per-target PLIC irq lines (level)
//  bus        : IOb master + interrupt hand-off channel (master modport)
//  busy_o     : FSM not idle (registered)
//  spurious_o : saturating count of claims that returned ID 0
module iob_plic_claim_ctrl #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       N_SOURCES  = 8,
  parameter int unsigned       N_TARGETS  = 2,
  parameter logic [ADDR_W-1:0] CLAIM_BASE = 'h0200,
  parameter int unsigned       TGT_STRIDE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [N_TARGETS-1:0] meip_i,
  iob_plic_claim_ctrl_if.master bus,
  output logic                 busy_o,
  output logic [7:0]           spurious_o
);

  localparam int unsigned ID_W  = $clog2(N_SOURCES + 1);
  localparam int unsigned TGT_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLAIM_REQ,
    S_CLAIM_WAIT,
    S_DISPATCH,
    S_SERVICE,
    S_CMPL_REQ
  } state_t;

  state_t           r_state;
  logic [TGT_W-1:0] r_tgt;
  logic [ID_W-1:0]  r_id;
  logic [TGT_W-1:0] r_rr_ptr;
  logic [7:0]       r_spurious;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [TGT_W-1:0] w_tgt_nxt;
  logic [ID_W-1:0]  w_id_nxt;
  logic [TGT_W-1:0] w_rr_nxt;
  logic [7:0]       w_spur_nxt;

  logic [2*N_TARGETS-1:0] w_meip2;
  logic [2*N_TARGETS-1:0] w_rot;
  logic                   w_sel_found;
  logic [TGT_W:0]         w_sel_off;
  logic [TGT_W:0]         w_sel_sum;
  logic [TGT_W-1:0]       w_sel_tgt;
  logic [TGT_W-1:0]       w_rr_inc;
  logic [ADDR_W-1:0]      w_addr;
  logic [ID_W-1:0]        w_rd_id;
  logic                   w_unused;

  // Round-robin pick: rotate a doubled copy of meip so bit 0 is the target at
  // rr_ptr, take the lowest set bit, then map the offset back with a wrap.
  assign w_meip2 = {meip_i, meip_i};
  assign w_rot   = w_meip2 >> r_rr_ptr;

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_off   = '0;
    for (int unsigned k = 0; k < N_TARGETS; k++) begin
      if (!w_sel_found && w_rot[k]) begin
        w_sel_found = 1'b1;
        w_sel_off   = (TGT_W+1)'(k);
      end
    end
    w_sel_sum = {1'b0, r_rr_ptr} + w_sel_off;
    if (w_sel_sum >= (TGT_W+1)'(N_TARGETS)) begin
      w_sel_sum = w_sel_sum - (TGT_W+1)'(N_TARGETS);
    end
    w_sel_tgt = w_sel_sum[TGT_W-1:0];
  end

  assign w_rr_inc = (r_tgt == TGT_W'(N_TARGETS - 1)) ? '0 : r_tgt + TGT_W'(1);
  assign w_addr   = CLAIM_BASE + ADDR_W'(r_tgt) * ADDR_W'(TGT_STRIDE);
  assign w_rd_id  = bus.iob_rdata_i[ID_W-1:0];
  assign w_unused = ^bus.iob_rdata_i[DATA_W-1:ID_W];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_tgt      <= '0;
      r_id       <= '0;
      r_rr_ptr   <= '0;
      r_spurious <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt      <= w_tgt_nxt;
      r_id       <= w_id_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_spurious <= w_spur_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tgt_nxt        = r_tgt;
    w_id_nxt         = r_id;
    w_rr_nxt         = r_rr_ptr;
    w_spur_nxt       = r_spurious;
    bus.iob_avalid_o = 1'b0;
    bus.iob_addr_o   = '0;
    bus.iob_wdata_o  = '0;
    bus.iob_wstrb_o  = '0;
    bus.irq_valid_o  = 1'b0;
    bus.irq_tgt_o    = '0;
    bus.irq_id_o     = '0;

    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_tgt_nxt   = w_sel_tgt;
          w_state_nxt = S_CLAIM_REQ;
        end
      end

      S_CLAIM_REQ: begin
        bus.iob_avalid_o = 1'b1;
        bus.iob_addr_o   = w_addr;
        if (bus.iob_ready_i) begin
          w_state_nxt = S_CLAIM_WAIT;
        end
      end

      S_CLAIM_WAIT: begin
        if (bus.iob_rvalid_i) begin
          w_id_nxt = w_rd_id;
          if (w_rd_id == '0) begin
            // Nothing to hand off; count it and move past this target.
            if (r_spurious != 8'hFF) begin
              w_spur_nxt = r_spurious + 8'd1;
            end
            w_rr_nxt    = w_rr_inc;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DISPATCH;
          end
        end
      end

      S_DISPATCH: begin
        bus.irq_valid_o = 1'b1;
        bus.irq_tgt_o   = r_tgt;
        bus.irq_id_o    = r_id;
        if (bus.irq_ready_i) begin
          w_state_nxt = S_SERVICE;
        end
      end

      S_SERVICE: begin
        if (bus.done_i) begin
          w_state_nxt = S_CMPL_REQ;
        end
      end

      S_CMPL_REQ: begin
        bus.iob_avalid_o = 1'b1;
        bus.iob_addr_o   = w_addr;
        bus.iob_wstrb_o  = '1;
        bus.iob_wdata_o  = DATA_W'(r_id);
        if (bus.iob_ready_i) begin
          w_rr_nxt    = w_rr_inc;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy_o     = r_busy;
  assign spurious_o = r_spurious;

endmodule
